// File: rtl/pixhist_pkg.sv
// Shared register map, CTRL layout and field offsets for the pixel-match histogram counter.
// Saturating counters are built when PIXHIST_SATURATE_EN is defined; otherwise counters wrap.
package pixhist_pkg;

    localparam int unsigned AddrCtrl      = 0;
    localparam int unsigned AddrStatus    = 1;
    localparam int unsigned AddrMatchBase = 2;
    localparam int unsigned AddrCountBase = 3;

    localparam int unsigned CtrlEnBit      = 0;
    localparam int unsigned CtrlOneshotBit = 1;
    localparam int unsigned CtrlIeBit      = 2;
    localparam int unsigned CtrlRdyBit     = 8;
    localparam int unsigned CtrlSeqLsb     = 16;
    localparam int unsigned SeqW           = 16;

    localparam int unsigned MaskLsb = 16;

    typedef struct packed {
        logic [SeqW-1:0] seq;
        logic            rdy;
        logic            ie;
        logic            oneshot;
        logic            en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_word(input ctrl_t c);
        logic [31:0] w;
        w                        = '0;
        w[CtrlEnBit]             = c.en;
        w[CtrlOneshotBit]        = c.oneshot;
        w[CtrlIeBit]             = c.ie;
        w[CtrlRdyBit]            = c.rdy;
        w[CtrlSeqLsb +: SeqW]    = c.seq;
        return w;
    endfunction

endpackage

// File: rtl/pixhist_chan.sv
// One colour channel: match/mask registers, compare stage, interval counter and snapshot.
// With PIXHIST_SATURATE_EN defined the counter and snapshot saturate and overflow is flagged.
module pixhist_chan
    import pixhist_pkg::*;
#(
    parameter int unsigned PW = 10,
    parameter int unsigned CW = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_en,
    input  logic          i_pix_valid,
    input  logic [PW-1:0] i_pix,
    input  logic          i_pps,
    input  logic          i_wr,
    input  logic [PW-1:0] i_wr_match,
    input  logic [PW-1:0] i_wr_mask,
    output logic [31:0]   o_match_word,
    output logic [CW-1:0] o_snap,
    output logic          o_ovf
);

    logic [PW-1:0] match_q, mask_q;
    logic          inc_q;
    logic [CW-1:0] cnt_q, snap_q;
    logic          sat_q, ovf_q;

    logic [CW:0]   sum_wide;
    logic [CW-1:0] sum;
    logic          sum_ovf;

    assign sum_wide = {1'b0, cnt_q} + {{CW{1'b0}}, inc_q};

`ifdef PIXHIST_SATURATE_EN
    assign sum     = sum_wide[CW] ? {CW{1'b1}} : sum_wide[CW-1:0];
    assign sum_ovf = sum_wide[CW];
`else
    logic unused_carry;
    assign unused_carry = sum_wide[CW];
    assign sum          = sum_wide[CW-1:0];
    assign sum_ovf      = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            match_q <= '0;
            mask_q  <= '0;
            inc_q   <= 1'b0;
            cnt_q   <= '0;
            snap_q  <= '0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (i_wr) begin
                match_q <= i_wr_match;
                mask_q  <= i_wr_mask;
            end
            inc_q <= i_en && i_pix_valid && (((i_pix ^ match_q) & mask_q) == '0);
            // The increment in flight on the strobe cycle belongs to the closing interval.
            if (i_pps) begin
                snap_q <= sum;
                cnt_q  <= '0;
                ovf_q  <= sat_q | sum_ovf;
                sat_q  <= 1'b0;
            end else begin
                cnt_q <= sum;
                sat_q <= sat_q | sum_ovf;
            end
        end
    end

    always_comb begin
        o_match_word                = '0;
        o_match_word[PW-1:0]        = match_q;
        o_match_word[MaskLsb +: PW] = mask_q;
    end

    assign o_snap = snap_q;
    assign o_ovf  = ovf_q;

endmodule

// File: rtl/pixhist_match.sv
// Pixel-match histogram counter top: CTRL/STATUS/SEQ, Wishbone decode and read mux.
// Define PIXHIST_SATURATE_EN for saturating counters with per-channel overflow status.
module pixhist_match
    import pixhist_pkg::*;
#(
    parameter int unsigned NCHAN = 3,
    parameter int unsigned PW    = 10,
    parameter int unsigned CW    = 32,
    localparam int unsigned AW   = $clog2(2*NCHAN+2)
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_pix_valid,
    input  logic [NCHAN*PW-1:0] i_pixels,
    input  logic              i_pps,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [AW-1:0]     i_wb_addr,
    input  logic [31:0]       i_wb_data,
    output logic              o_wb_stall,
    output logic              o_wb_ack,
    output logic [31:0]       o_wb_data,
    output logic              o_int
);

    ctrl_t       ctrl_q;
    logic        ack_q;
    logic [31:0] rdata_q;

    logic             bus_stb, bus_wr, wr_ctrl;
    logic [NCHAN-1:0] wr_match;
    logic [NCHAN-1:0] ovf;
    logic [31:0]      match_word [NCHAN];
    logic [CW-1:0]    snap       [NCHAN];
    logic [31:0]      rd_mux;

    logic unused_wdata;
    assign unused_wdata = ^i_wb_data;

    assign bus_stb = i_wb_cyc && i_wb_stb;
    assign bus_wr  = bus_stb && i_wb_we;
    assign wr_ctrl = bus_wr && (i_wb_addr == AW'(AddrCtrl));

    always_comb begin
        wr_match = '0;
        for (int k = 0; k < int'(NCHAN); k++) begin
            wr_match[k] = bus_wr && (i_wb_addr == AW'(AddrMatchBase + 2 * k));
        end
    end

    for (genvar k = 0; k < int'(NCHAN); k++) begin : g_chan
        pixhist_chan #(
            .PW (PW),
            .CW (CW)
        ) u_chan (
            .i_clk        (i_clk),
            .i_reset      (i_reset),
            .i_en         (ctrl_q.en),
            .i_pix_valid  (i_pix_valid),
            .i_pix        (i_pixels[k*PW +: PW]),
            .i_pps        (i_pps),
            .i_wr         (wr_match[k]),
            .i_wr_match   (i_wb_data[PW-1:0]),
            .i_wr_mask    (i_wb_data[MaskLsb +: PW]),
            .o_match_word (match_word[k]),
            .o_snap       (snap[k]),
            .o_ovf        (ovf[k])
        );
    end

    // Unmapped addresses fall through to zero.
    always_comb begin
        rd_mux = '0;
        if (i_wb_addr == AW'(AddrCtrl)) begin
            rd_mux = ctrl_word(ctrl_q);
        end else if (i_wb_addr == AW'(AddrStatus)) begin
            rd_mux = 32'(ovf);
        end
        for (int k = 0; k < int'(NCHAN); k++) begin
            if (i_wb_addr == AW'(AddrMatchBase + 2 * k)) begin
                rd_mux = match_word[k];
            end
            if (i_wb_addr == AW'(AddrCountBase + 2 * k)) begin
                rd_mux = 32'(snap[k]);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ctrl_q  <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= bus_stb;
            if (bus_stb) begin
                rdata_q <= rd_mux;
            end
            // A CTRL write beats the one-shot auto-clear of EN.
            if (wr_ctrl) begin
                ctrl_q.en      <= i_wb_data[CtrlEnBit];
                ctrl_q.oneshot <= i_wb_data[CtrlOneshotBit];
                ctrl_q.ie      <= i_wb_data[CtrlIeBit];
            end else if (i_pps && ctrl_q.oneshot) begin
                ctrl_q.en <= 1'b0;
            end
            // Snapshot-ready set beats a same-cycle write-1-clear.
            if (i_pps) begin
                ctrl_q.rdy <= 1'b1;
                ctrl_q.seq <= ctrl_q.seq + 16'd1;
            end else if (wr_ctrl && i_wb_data[CtrlRdyBit]) begin
                ctrl_q.rdy <= 1'b0;
            end
        end
    end

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = ack_q;
    assign o_wb_data  = rdata_q;
    assign o_int      = ctrl_q.rdy && ctrl_q.ie;

endmodule
